control_sequencer: RTL
======================

# control_sequencer

Fetch-decode-execute control unit for the 6-bit CPU. It sits directly upstream of the 8-to-1 6-bit bus multiplexer: it drives the multiplexer's 3-bit `sel` each cycle and asserts the register and memory load strobes that capture the selected bus value. It is a Moore state machine. Its outputs are decoded from the registered state and the current instruction register contents.

## Interface
- No parameters. Widths are fixed: 6-bit data, 3-bit bus select.
- `clk` input 1: system clock. All state changes on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `run` input 1: level. When high, execution starts or continues.
- `ir` input 6: instruction register contents. Opcode is `ir[5:3]`; `ir[2:0]` is the immediate.
- `bus_sel` output 3: drives the bus multiplexer select.
  - 0 = PC, 1 = MEM data, 2 = IR immediate (zero-extended), 3 = A, 4 = B, 5 = ALU (A+B).
  - 6 and 7 = constant zero.
- `pc_inc` output 1: PC <= PC+1, wrapping mod 64.
- `pc_load` output 1: PC <= bus.
- `mar_load` output 1: MAR <= bus.
- `ir_load` output 1: IR <= bus.
- `a_load` output 1: A <= bus.
- `b_load` output 1: B <= bus.
- `mem_we` output 1: mem[MAR] <= bus.
- `halted` output 1: high while in HALT.

## Operation
- States: IDLE, F0, F1, DEC, OP1, EXE, HALT. Encoding is free; there must be no unreachable lock-up states.
- Default in every state: all strobes 0 and `bus_sel`=6.

State behaviour:
- **IDLE:** if `run`=1, go to F0; otherwise stay.
- **F0:** `bus_sel`=0, `mar_load`=1. Then go to F1.
  - `run` is sampled on entry to F0, i.e. only at instruction boundaries.
  - Transitions into F0 from DEC, OP1 or EXE go to IDLE instead if `run`=0 in that cycle.
- **F1:** `bus_sel`=1, `ir_load`=1, `pc_inc`=1. Then go to DEC.
- **DEC:** action depends on opcode `ir[5:3]`.
  - 000 NOP: no strobes. Go to F0.
  - 001 LDI: `bus_sel`=2, `a_load`=1. Go to F0.
  - 100 ADD: `bus_sel`=5, `a_load`=1. Go to F0.
  - 101 MOVB: `bus_sel`=3, `b_load`=1. Go to F0.
  - 010 LDA, 011 STA, 110 JMP: `bus_sel`=0, `mar_load`=1, `pc_inc`=1. Go to OP1. This fetches the operand word.
  - 111 HLT: no strobes. Go to HALT.
- **OP1:**
  - LDA/STA: `bus_sel`=1, `mar_load`=1. Go to EXE.
  - JMP: `bus_sel`=1, `pc_load`=1. Go to F0.
- **EXE:**
  - LDA: `bus_sel`=1, `a_load`=1.
  - STA: `bus_sel`=3, `mem_we`=1.
  - Then go to F0.
- **HALT:** `halted`=1 and all strobes 0. Only `rst` leaves HALT; `run` is ignored.
- `pc_inc` and `pc_load` are never asserted together.
- At most one of `a_load`/`b_load`/`ir_load`/`mem_we` is asserted per cycle.

## Timing
- Reset, synchronous: the state is IDLE after the first rising edge with `rst`=1.
  - All outputs are 0 except `bus_sel`=6.
  - `rst` overrides every transition, including mid-instruction and in HALT. There is no partial-instruction completion.
- Outputs are combinational from the registered state plus `ir`. They are valid throughout the cycle and consumed at the next rising edge.
- `ir` changes only via `ir_load`, so it is stable from DEC onward.
- Cycle counts per instruction, from F0:
  - NOP/LDI/ADD/MOVB: 3 cycles.
  - JMP: 4 cycles.
  - LDA/STA: 5 cycles.
  - HLT: reaches HALT 3 cycles after F0.
- `run` start: `run` high in IDLE at edge N puts the state in F0 at N+1, so the first `mar_load` occurs in cycle N+1.
- `run` pause: `run` low during the final cycle of an instruction causes IDLE next. `run` low in any other cycle has no effect until the instruction finishes.
- PC wrap (63+1=0) is owned by the PC register. The sequencer only pulses `pc_inc`.

## Test plan
- **Reset/idle:** assert `rst` for 2 cycles with `run`=1, then release.
  - Required: `bus_sel`=6, all strobes 0 and `halted`=0 during reset.
  - Required: F0 in the first cycle after release, with `bus_sel`=0 and `mar_load`=1.
- **LDI:** `ir`=6'b001_101.
  - Required: `ir_load`=1 with `bus_sel`=1 in F1.
  - Required: `a_load`=1 with `bus_sel`=2 in DEC.
  - Required: F0 (`mar_load`) in the 4th cycle.
- **LDA and STA:** `ir`=6'b010_000, then 6'b011_000.
  - Required for LDA: DEC→OP1→EXE strobe sequence of (`bus_sel`=0, `mar_load`, `pc_inc`), then (1, `mar_load`), then (1, `a_load`).
  - Required for STA: the EXE cycle has `bus_sel`=3 and `mem_we`=1.
  - Required: 5 cycles per instruction.
- **JMP:** `ir`=6'b110_000.
  - Required: in OP1, `pc_load`=1 with `bus_sel`=1 and `pc_inc`=0.
  - Required: F0 next.
- **Pause:** drop `run` in the F1 of an ADD.
  - Required: ADD completes (`a_load`, `bus_sel`=5), then IDLE with no further `mar_load`.
  - Required: raising `run` again resumes at F0.
- **HLT and reset mid-op:** HLT with `run` held high.
  - Required: `halted`=1 for 10+ cycles with no strobes.
  - Then assert `rst` during OP1 of an LDA. Required: IDLE next cycle, with no EXE strobe ever issued.

Source files
------------

// File: rtl/control_sequencer.sv
// Fetch-decode-execute sequencer for the 6-bit CPU: Moore FSM driving the bus
// select and the register/memory load strobes from the registered state and IR.
module control_sequencer (
   input  logic       clk,
   input  logic       rst,
   input  logic       run,
   input  logic [5:0] ir,
   output logic [2:0] bus_sel,
   output logic       pc_inc,
   output logic       pc_load,
   output logic       mar_load,
   output logic       ir_load,
   output logic       a_load,
   output logic       b_load,
   output logic       mem_we,
   output logic       halted
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      F0   = 3'd1,
      F1   = 3'd2,
      DEC  = 3'd3,
      OP1  = 3'd4,
      EXE  = 3'd5,
      HALT = 3'd6
   } state_t;

   localparam logic [2:0] OP_NOP  = 3'b000;
   localparam logic [2:0] OP_LDI  = 3'b001;
   localparam logic [2:0] OP_LDA  = 3'b010;
   localparam logic [2:0] OP_STA  = 3'b011;
   localparam logic [2:0] OP_ADD  = 3'b100;
   localparam logic [2:0] OP_MOVB = 3'b101;
   localparam logic [2:0] OP_JMP  = 3'b110;
   localparam logic [2:0] OP_HLT  = 3'b111;

   localparam logic [2:0] SEL_PC   = 3'd0;
   localparam logic [2:0] SEL_MEM  = 3'd1;
   localparam logic [2:0] SEL_IMM  = 3'd2;
   localparam logic [2:0] SEL_A    = 3'd3;
   localparam logic [2:0] SEL_ALU  = 3'd5;
   localparam logic [2:0] SEL_ZERO = 3'd6;

   state_t     state;
   logic [2:0] opcode;
   state_t     boundary;

   assign opcode   = ir[5:3];
   // Instruction boundary: run is only honoured here.
   assign boundary = run ? F0 : IDLE;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE: state <= run ? F0 : IDLE;
            F0:   state <= F1;
            F1:   state <= DEC;
            DEC: begin
               case (opcode)
                  OP_LDA, OP_STA, OP_JMP: state <= OP1;
                  OP_HLT:                 state <= HALT;
                  default:                state <= boundary;
               endcase
            end
            OP1:  state <= (opcode == OP_JMP) ? boundary : EXE;
            EXE:  state <= boundary;
            HALT: state <= HALT;
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      bus_sel  = SEL_ZERO;
      pc_inc   = 1'b0;
      pc_load  = 1'b0;
      mar_load = 1'b0;
      ir_load  = 1'b0;
      a_load   = 1'b0;
      b_load   = 1'b0;
      mem_we   = 1'b0;
      halted   = 1'b0;
      case (state)
         F0: begin
            bus_sel  = SEL_PC;
            mar_load = 1'b1;
         end
         F1: begin
            bus_sel = SEL_MEM;
            ir_load = 1'b1;
            pc_inc  = 1'b1;
         end
         DEC: begin
            case (opcode)
               OP_LDI:  begin bus_sel = SEL_IMM; a_load = 1'b1; end
               OP_ADD:  begin bus_sel = SEL_ALU; a_load = 1'b1; end
               OP_MOVB: begin bus_sel = SEL_A;   b_load = 1'b1; end
               OP_LDA, OP_STA, OP_JMP: begin
                  // Fetch the operand word and step past it.
                  bus_sel  = SEL_PC;
                  mar_load = 1'b1;
                  pc_inc   = 1'b1;
               end
               default: ;
            endcase
         end
         OP1: begin
            bus_sel = SEL_MEM;
            if (opcode == OP_JMP) pc_load  = 1'b1;
            else                  mar_load = 1'b1;
         end
         EXE: begin
            if (opcode == OP_LDA) begin
               bus_sel = SEL_MEM;
               a_load  = 1'b1;
            end else if (opcode == OP_STA) begin
               bus_sel = SEL_A;
               mem_we  = 1'b1;
            end
         end
         HALT: halted = 1'b1;
         default: ;
      endcase
   end

endmodule
